if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 122 ++++++++++++
 tb/tb_if_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and event counters.
// Cycle priority is reset > flush > stall > memory wait > normal fetch.
module if_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] target_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    input  logic        imem_ready_i,
    output logic [31:0] pc_o,
    output logic [31:0] ifid_pc4_o,
    output logic [31:0] ifid_instr_o,
    output logic        ifid_valid_o,
    output logic [15:0] stall_cnt_o,
    output logic [15:0] bubble_cnt_o
);

    typedef enum logic [1:0] {
        CYC_FETCH = 2'd0,
        CYC_WAIT  = 2'd1,
        CYC_STALL = 2'd2,
        CYC_FLUSH = 2'd3
    } cycle_kind_t;

    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [31:0] ifid_pc4_reg;
    logic [31:0] ifid_pc4_next;
    logic [31:0] ifid_instr_reg;
    logic [31:0] ifid_instr_next;
    logic        ifid_valid_reg;
    logic        ifid_valid_next;
    logic [15:0] stall_cnt_reg;
    logic [15:0] stall_cnt_next;
    logic [15:0] bubble_cnt_reg;
    logic [15:0] bubble_cnt_next;

    cycle_kind_t cycle_kind;
    logic [31:0] pc4;
    logic [31:0] target_aligned;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    // Natural 32-bit overflow gives the required wrap from 0xFFFFFFFC to 0.
    assign pc4            = pc_reg + 32'd4;
    assign target_aligned = target_i & 32'hFFFF_FFFC;

    always_comb begin
        cycle_kind = CYC_FETCH;
        if (flush_i) begin
            cycle_kind = CYC_FLUSH;
        end else if (stall_i) begin
            cycle_kind = CYC_STALL;
        end else if (!imem_ready_i) begin
            cycle_kind = CYC_WAIT;
        end
    end

    always_comb begin
        pc_next         = pc_reg;
        ifid_pc4_next   = ifid_pc4_reg;
        ifid_instr_next = ifid_instr_reg;
        ifid_valid_next = ifid_valid_reg;
        stall_cnt_next  = stall_cnt_reg;
        bubble_cnt_next = bubble_cnt_reg;
        case (cycle_kind)
            CYC_FLUSH: begin
                pc_next         = target_aligned;
                ifid_pc4_next   = 32'd0;
                ifid_instr_next = 32'd0;
                ifid_valid_next = 1'b0;
            end
            CYC_STALL: begin
                stall_cnt_next = sat_inc(stall_cnt_reg);
            end
            // A memory wait keeps the PC so the same address is re-presented next cycle.
            CYC_WAIT: begin
                ifid_pc4_next   = 32'd0;
                ifid_instr_next = 32'd0;
                ifid_valid_next = 1'b0;
                bubble_cnt_next = sat_inc(bubble_cnt_reg);
            end
            default: begin
                pc_next         = pc4;
                ifid_pc4_next   = pc4;
                ifid_instr_next = imem_data_i;
                ifid_valid_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_reg         <= 32'd0;
            ifid_pc4_reg   <= 32'd0;
            ifid_instr_reg <= 32'd0;
            ifid_valid_reg <= 1'b0;
            stall_cnt_reg  <= 16'd0;
            bubble_cnt_reg <= 16'd0;
        end else begin
            pc_reg         <= pc_next;
            ifid_pc4_reg   <= ifid_pc4_next;
            ifid_instr_reg <= ifid_instr_next;
            ifid_valid_reg <= ifid_valid_next;
            stall_cnt_reg  <= stall_cnt_next;
            bubble_cnt_reg <= bubble_cnt_next;
        end
    end

    assign imem_addr_o  = pc_reg;
    assign pc_o         = pc_reg;
    assign ifid_pc4_o   = ifid_pc4_reg;
    assign ifid_instr_o = ifid_instr_reg;
    assign ifid_valid_o = ifid_valid_reg;
    assign stall_cnt_o  = stall_cnt_reg;
    assign bubble_cnt_o = bubble_cnt_reg;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized cycles against a behavioural model.
module tb_if_stage;

    logic        clk_i;
    logic        rst_i;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] target_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic        imem_ready_i;
    logic [31:0] pc_o;
    logic [31:0] ifid_pc4_o;
    logic [31:0] ifid_instr_o;
    logic        ifid_valid_o;
    logic [15:0] stall_cnt_o;
    logic [15:0] bubble_cnt_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_pc4;
    logic [31:0] m_instr;
    logic        m_valid;
    int          m_stall;
    int          m_bubble;

    if_stage dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .target_i     (target_i),
        .imem_addr_o  (imem_addr_o),
        .imem_data_i  (imem_data_i),
        .imem_ready_i (imem_ready_i),
        .pc_o         (pc_o),
        .ifid_pc4_o   (ifid_pc4_o),
        .ifid_instr_o (ifid_instr_o),
        .ifid_valid_o (ifid_valid_o),
        .stall_cnt_o  (stall_cnt_o),
        .bubble_cnt_o (bubble_cnt_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Memory content is a fixed function of address; address 0 holds 0x20080005.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h2008_0005;
    endfunction

    always_comb imem_data_i = mem_word(imem_addr_o);

    // Drive one cycle, advance past the edge, and update the model from the cycle rules.
    task automatic drive(input logic r, input logic f, input logic s, input logic rd,
                         input logic [31:0] t, input bit show);
        rst_i        = r;
        flush_i      = f;
        stall_i      = s;
        imem_ready_i = rd;
        target_i     = t;
        @(posedge clk_i);
        #1;
        if (r) begin
            m_pc = 0; m_pc4 = 0; m_instr = 0; m_valid = 0; m_stall = 0; m_bubble = 0;
        end else if (f) begin
            m_pc = {t[31:2], 2'b00}; m_pc4 = 0; m_instr = 0; m_valid = 0;
        end else if (s) begin
            if (m_stall < 65535) m_stall = m_stall + 1;
        end else if (!rd) begin
            m_pc4 = 0; m_instr = 0; m_valid = 0;
            if (m_bubble < 65535) m_bubble = m_bubble + 1;
        end else begin
            m_instr = mem_word(m_pc);
            m_pc    = m_pc + 32'd4;
            m_pc4   = m_pc;
            m_valid = 1'b1;
        end
        if (show)
            $display("[%0t] rst=%0b flush=%0b stall=%0b ready=%0b tgt=%h -> pc=%h pc4=%h instr=%h v=%0b sc=%0d bc=%0d",
                     $time, r, f, s, rd, t, pc_o, ifid_pc4_o, ifid_instr_o, ifid_valid_o,
                     stall_cnt_o, bubble_cnt_o);
    endtask

    task automatic test_reset;
        drive(1, $urandom_range(0, 1), $urandom_range(0, 1), 1, $urandom, 1);
        drive(1, 1, 1, 0, 32'hDEAD_BEEF, 1);
        checks++; if (pc_o !== 32'd0) begin errors++; $display("FAIL reset_pc got %h want 0", pc_o); end
        checks++; if (ifid_pc4_o !== 32'd0) begin errors++; $display("FAIL reset_pc4 got %h want 0", ifid_pc4_o); end
        checks++; if (ifid_instr_o !== 32'd0) begin errors++; $display("FAIL reset_instr got %h want 0", ifid_instr_o); end
        checks++; if (ifid_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", ifid_valid_o); end
        checks++; if (stall_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt_o); end
        checks++; if (bubble_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_bubble_cnt got %0d want 0", bubble_cnt_o); end
        drive(0, 0, 0, 1, 32'd0, 1);
        checks++; if (pc_o !== 32'd4) begin errors++; $display("FAIL first_fetch_pc got %h want 4", pc_o); end
        checks++; if (ifid_pc4_o !== 32'd4) begin errors++; $display("FAIL first_fetch_pc4 got %h want 4", ifid_pc4_o); end
        checks++; if (ifid_instr_o !== 32'h2008_0005) begin errors++; $display("FAIL first_fetch_instr got %h want 20080005", ifid_instr_o); end
        checks++; if (ifid_valid_o !== 1'b1) begin errors++; $display("FAIL first_fetch_valid got %0b want 1", ifid_valid_o); end
    endtask

    task automatic test_stall;
        drive(1, 0, 0, 1, 32'd0, 1);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 32'd0, 1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, $urandom_range(0, 1), $urandom, 1);
            checks++; if (pc_o !== 32'h10) begin errors++; $display("FAIL stall_pc[%0d] got %h want 10", i, pc_o); end
            checks++; if (ifid_pc4_o !== 32'h10) begin errors++; $display("FAIL stall_pc4[%0d] got %h want 10", i, ifid_pc4_o); end
            checks++; if (ifid_instr_o !== mem_word(32'hC)) begin errors++; $display("FAIL stall_instr[%0d] got %h want %h", i, ifid_instr_o, mem_word(32'hC)); end
            checks++; if (ifid_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %0b want 1", i, ifid_valid_o); end
        end
        checks++; if (stall_cnt_o !== 16'd3) begin errors++; $display("FAIL stall_cnt got %0d want 3", stall_cnt_o); end
    endtask

    task automatic test_flush_over_stall;
        stall_i = 1; flush_i = 1;
        #1;
        checks++; if (imem_addr_o !== 32'h10) begin errors++; $display("FAIL flush_addr_same_cycle got %h want 10", imem_addr_o); end
        drive(0, 1, 1, 1, 32'h43, 1);
        checks++; if (pc_o !== 32'h40) begin errors++; $display("FAIL flush_pc got %h want 40", pc_o); end
        checks++; if (ifid_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", ifid_valid_o); end
        checks++; if (ifid_instr_o !== 32'd0) begin errors++; $display("FAIL flush_instr got %h want 0", ifid_instr_o); end
        checks++; if (ifid_pc4_o !== 32'd0) begin errors++; $display("FAIL flush_pc4 got %h want 0", ifid_pc4_o); end
        checks++; if (stall_cnt_o !== 16'd3) begin errors++; $display("FAIL flush_stall_cnt got %0d want 3", stall_cnt_o); end
    endtask

    task automatic test_wait;
        drive(1, 0, 0, 1, 32'd0, 1);
        drive(0, 0, 0, 1, 32'd0, 1);
        drive(0, 0, 0, 1, 32'd0, 1);
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 32'd0, 1);
            checks++; if (pc_o !== 32'h8) begin errors++; $display("FAIL wait_pc[%0d] got %h want 8", i, pc_o); end
            checks++; if (ifid_valid_o !== 1'b0) begin errors++; $display("FAIL wait_valid[%0d] got %0b want 0", i, ifid_valid_o); end
        end
        checks++; if (bubble_cnt_o !== 16'd2) begin errors++; $display("FAIL wait_bubble_cnt got %0d want 2", bubble_cnt_o); end
        drive(0, 0, 0, 1, 32'd0, 1);
        checks++; if (pc_o !== 32'hC) begin errors++; $display("FAIL wait_resume_pc got %h want C", pc_o); end
        checks++; if (ifid_valid_o !== 1'b1) begin errors++; $display("FAIL wait_resume_valid got %0b want 1", ifid_valid_o); end
        checks++; if (ifid_instr_o !== mem_word(32'h8)) begin errors++; $display("FAIL wait_resume_instr got %h want %h", ifid_instr_o, mem_word(32'h8)); end
        // Stall while memory is not ready: IF/ID holds, no bubble counted.
        drive(0, 0, 1, 0, 32'd0, 1);
        checks++; if (ifid_valid_o !== 1'b1) begin errors++; $display("FAIL stall_in_wait_valid got %0b want 1", ifid_valid_o); end
        checks++; if (ifid_pc4_o !== 32'hC) begin errors++; $display("FAIL stall_in_wait_pc4 got %h want C", ifid_pc4_o); end
        checks++; if (bubble_cnt_o !== 16'd2) begin errors++; $display("FAIL stall_in_wait_bubble got %0d want 2", bubble_cnt_o); end
        checks++; if (stall_cnt_o !== 16'd1) begin errors++; $display("FAIL stall_in_wait_stall got %0d want 1", stall_cnt_o); end
    endtask

    task automatic test_wrap_and_saturate;
        drive(1, 0, 0, 1, 32'd0, 1);
        drive(0, 1, 0, 1, 32'hFFFF_FFFF, 1);
        checks++; if (pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target_pc got %h want FFFFFFFC", pc_o); end
        drive(0, 0, 0, 1, 32'd0, 1);
        checks++; if (pc_o !== 32'd0) begin errors++; $display("FAIL wrap_pc got %h want 0", pc_o); end
        checks++; if (ifid_pc4_o !== 32'd0) begin errors++; $display("FAIL wrap_pc4 got %h want 0", ifid_pc4_o); end
        checks++; if (ifid_instr_o !== mem_word(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_instr got %h want %h", ifid_instr_o, mem_word(32'hFFFF_FFFC)); end
        for (int i = 0; i < 65534; i++) drive(0, 0, 1, $urandom_range(0, 1), 32'd0, 0);
        checks++; if (stall_cnt_o !== 16'hFFFE) begin errors++; $display("FAIL sat_before got %h want FFFE", stall_cnt_o); end
        drive(0, 0, 1, 1, 32'd0, 1);
        checks++; if (stall_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %h want FFFF", stall_cnt_o); end
        drive(0, 0, 1, 1, 32'd0, 1);
        checks++; if (stall_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want FFFF", stall_cnt_o); end
        checks++; if (pc_o !== 32'd0) begin errors++; $display("FAIL sat_pc got %h want 0", pc_o); end
    endtask

    task automatic test_reset_mid_stall;
        drive(0, 0, 0, 0, 32'd0, 1);
        drive(0, 0, 1, 1, 32'd0, 1);
        drive(1, 1, 1, 1, 32'h1234_5678, 1);
        checks++; if (pc_o !== 32'd0) begin errors++; $display("FAIL rst_mid_pc got %h want 0", pc_o); end
        checks++; if (ifid_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %0b want 0", ifid_valid_o); end
        checks++; if (ifid_pc4_o !== 32'd0 || ifid_instr_o !== 32'd0) begin errors++; $display("FAIL rst_mid_ifid got pc4=%h instr=%h want 0/0", ifid_pc4_o, ifid_instr_o); end
        checks++; if (stall_cnt_o !== 16'd0 || bubble_cnt_o !== 16'd0) begin errors++; $display("FAIL rst_mid_cnt got %0d/%0d want 0/0", stall_cnt_o, bubble_cnt_o); end
        checks++; if (imem_addr_o !== 32'd0) begin errors++; $display("FAIL rst_mid_addr got %h want 0", imem_addr_o); end
        drive(0, 0, 0, 1, 32'd0, 1);
        checks++; if (pc_o !== 32'd4) begin errors++; $display("FAIL rst_mid_resume_pc got %h want 4", pc_o); end
        checks++; if (ifid_instr_o !== 32'h2008_0005) begin errors++; $display("FAIL rst_mid_resume_instr got %h want 20080005", ifid_instr_o); end
    endtask

    task automatic test_random;
        drive(1, 0, 0, 1, 32'd0, 1);
        for (int i = 0; i < 400; i++) begin
            logic r, f, s, rd;
            r  = ($urandom_range(0, 99) < 3);
            f  = ($urandom_range(0, 99) < 10);
            s  = ($urandom_range(0, 99) < 30);
            rd = ($urandom_range(0, 99) < 75);
            drive(r, f, s, rd, $urandom, 1);
            checks++; if (pc_o !== m_pc) begin errors++; $display("FAIL rand_pc[%0d] got %h want %h", i, pc_o, m_pc); end
            checks++; if (imem_addr_o !== m_pc) begin errors++; $display("FAIL rand_addr[%0d] got %h want %h", i, imem_addr_o, m_pc); end
            checks++; if (ifid_pc4_o !== m_pc4) begin errors++; $display("FAIL rand_pc4[%0d] got %h want %h", i, ifid_pc4_o, m_pc4); end
            checks++; if (ifid_instr_o !== m_instr) begin errors++; $display("FAIL rand_instr[%0d] got %h want %h", i, ifid_instr_o, m_instr); end
            checks++; if (ifid_valid_o !== m_valid) begin errors++; $display("FAIL rand_valid[%0d] got %0b want %0b", i, ifid_valid_o, m_valid); end
            checks++; if (stall_cnt_o !== 16'(m_stall)) begin errors++; $display("FAIL rand_stall_cnt[%0d] got %0d want %0d", i, stall_cnt_o, m_stall); end
            checks++; if (bubble_cnt_o !== 16'(m_bubble)) begin errors++; $display("FAIL rand_bubble_cnt[%0d] got %0d want %0d", i, bubble_cnt_o, m_bubble); end
        end
    endtask

    initial begin
        rst_i = 1; flush_i = 0; stall_i = 0; imem_ready_i = 1; target_i = 0;
        m_pc = 0; m_pc4 = 0; m_instr = 0; m_valid = 0; m_stall = 0; m_bubble = 0;
        test_reset();
        test_stall();
        test_flush_over_stall();
        test_wait();
        test_wrap_and_saturate();
        test_reset_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
